paddsub_seq_16bit: RTL and testbench

- Sequential, multi-cycle counterpart of the combinational nibble-parallel add/sub unit.
- Accepts one operand pair through a start/busy/done handshake and processes one 4-bit signed lane per clock, saturating each lane result to [-8, +7].
- Supports both directions, add (is_sub=0) and subtract (is_sub=1).
- Sits in the EX stage as the low-area PADDSB/PSUBSB option, with a per-lane saturation mask for debug and flags.

---
 rtl/paddsub_seq_16bit_if.sv | 25 ++
 rtl/paddsub_seq_16bit.sv | 100 ++++++++++
 tb/tb_paddsub_seq_16bit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/paddsub_seq_16bit_if.sv
// Handshake and data bundle for the sequential lane-wise saturating add/sub unit.
// The master drives the request side; the slave returns status and results.
interface paddsub_seq_16bit_if #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
);
  logic                    start;
  logic                    is_sub;
  logic [WIDTH-1:0]        a_in;
  logic [WIDTH-1:0]        b_in;
  logic                    busy;
  logic                    done;
  logic [WIDTH-1:0]        sum_out;
  logic [WIDTH/LANE-1:0]   sat_mask;

  modport master (
    output start, is_sub, a_in, b_in,
    input  busy, done, sum_out, sat_mask
  );

  modport slave (
    input  start, is_sub, a_in, b_in,
    output busy, done, sum_out, sat_mask
  );
endinterface

// File: rtl/paddsub_seq_16bit.sv
// Multi-cycle lane-wise saturating add/sub: one signed LANE-bit lane per clock,
// results clamped to the signed lane range, with a per-lane saturation mask.
module paddsub_seq_16bit #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  paddsub_seq_16bit_if.slave bus
);
  localparam int LANES = WIDTH / LANE;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             sub_reg;
  logic [LANES-1:0] mask_reg;
  logic             load, step;

  // Every lane is evaluated from the latched operands; the index picks which one is committed.
  logic [WIDTH-1:0] lane_res;
  logic [LANES-1:0] lane_sat;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE:0] ext_a, ext_b, r;
      assign ext_a = {a_reg[gi*LANE+LANE-1], a_reg[gi*LANE +: LANE]};
      assign ext_b = {b_reg[gi*LANE+LANE-1], b_reg[gi*LANE +: LANE]};
      assign r     = sub_reg ? (ext_a - ext_b) : (ext_a + ext_b);
      // The top two bits disagree exactly when r leaves the signed lane range; r[LANE] gives the sign.
      assign lane_sat[gi] = r[LANE] ^ r[LANE-1];
      assign lane_res[gi*LANE +: LANE] = lane_sat[gi] ? {r[LANE], {(LANE-1){~r[LANE]}}}
                                                      : r[LANE-1:0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      sum_reg   <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_reg    <= bus.a_in;
        b_reg    <= bus.b_in;
        sub_reg  <= bus.is_sub;
        idx_reg  <= '0;
        sum_reg  <= '0;
        mask_reg <= '0;
      end
      if (step) begin
        sum_reg[idx_reg*LANE +: LANE] <= lane_res[idx_reg*LANE +: LANE];
        mask_reg[idx_reg]             <= lane_sat[idx_reg];
        if (idx_reg != LAST_IDX) begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.sum_out  = sum_reg;
  assign bus.sat_mask = mask_reg;
endmodule

// File: tb/tb_paddsub_seq_16bit.sv
// Directed bench for paddsub_seq_16bit: scoreboard of expected results,
// one line printed per completed transaction.
module tb_paddsub_seq_16bit;
  typedef struct packed {
    logic [15:0] sum;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs    = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  paddsub_seq_16bit_if #(.WIDTH(16), .LANE(4)) bus ();

  paddsub_seq_16bit #(.WIDTH(16), .LANE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer lane arithmetic with explicit clamping.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    exp_t e;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      logic [3:0] an, bn;
      int x, y, r;
      an = a[l*4 +: 4];
      bn = b[l*4 +: 4];
      x  = an[3] ? int'(an) - 16 : int'(an);
      y  = bn[3] ? int'(bn) - 16 : int'(bn);
      r  = sub ? x - y : x + y;
      if (r > 7) begin
        e.sum[l*4 +: 4] = 4'h7;
        e.mask[l]       = 1'b1;
      end else if (r < -8) begin
        e.sum[l*4 +: 4] = 4'h8;
        e.mask[l]       = 1'b1;
      end else begin
        e.sum[l*4 +: 4] = 4'(r);
      end
    end
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"},  {16'h0, bus.sum_out},  {16'h0, e.sum});
      check({tag, "_mask"}, {28'h0, bus.sat_mask}, {28'h0, e.mask});
      $display("txn %s: sum_out=%h sat_mask=%b expected %h/%b",
               tag, bus.sum_out, bus.sat_mask, e.sum, e.mask);
    end
  endtask

  // One operation; disturb=1 re-pulses start and scrambles the operands mid-CALC.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic disturb);
    int cycles;
    @(negedge clk);
    bus.a_in   = a;
    bus.b_in   = b;
    bus.is_sub = sub;
    bus.start  = 1'b1;
    sb.push_back(model(a, b, sub));
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_accept"}, {31'h0, bus.busy}, 32'd1);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (disturb && cycles == 1) begin
        bus.start  = 1'b1;
        bus.a_in   = ~a;
        bus.b_in   = a ^ b;
        bus.is_sub = ~sub;
      end else if (disturb && cycles == 2) begin
        bus.start = 1'b0;
      end
    end
    check({tag, "_latency"}, cycles, 32'd4);
    compare_result(tag);
    @(negedge clk);
    check({tag, "_done_drop"}, {30'h0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    int cycles, ndone, last_done, seen;
    logic prev_done;
    bus.start  = 1'b0;
    bus.is_sub = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy_done", {30'h0, bus.busy, bus.done}, 32'd0);
    check("reset_sum",  {16'h0, bus.sum_out}, 32'd0);
    check("reset_mask", {28'h0, bus.sat_mask}, 32'd0);

    run_op("add_nosat",  16'h1284, 16'h1111, 1'b0, 1'b0);
    check("add_nosat_const", {16'h0, bus.sum_out}, 32'h2395);
    run_op("sub_inverse", 16'h2395, 16'h1111, 1'b1, 1'b0);
    check("sub_inverse_const", {16'h0, bus.sum_out}, 32'h1284);
    run_op("sat_pos_add", 16'h7777, 16'h1111, 1'b0, 1'b0);
    run_op("sat_neg_add", 16'h8888, 16'h8888, 1'b0, 1'b0);
    run_op("sat_pos_sub", 16'h7777, 16'h8888, 1'b1, 1'b0);
    run_op("mixed_sub",   16'h7F80, 16'h1111, 1'b1, 1'b0);
    check("mixed_sub_const", {12'h0, bus.sat_mask, bus.sum_out}, {12'h0, 4'b0010, 16'h6E8F});
    run_op("disturbed",   16'h1284, 16'h1111, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end

    // Held start: accepts at 6-cycle intervals while start stays high.
    @(negedge clk);
    bus.a_in   = 16'h3C5A;
    bus.b_in   = 16'h6B27;
    bus.is_sub = 1'b0;
    bus.start  = 1'b1;
    repeat (4) sb.push_back(model(16'h3C5A, 16'h6B27, 1'b0));
    ndone = 0;
    last_done = 0;
    prev_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 20) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (prev_done) check("held_done_width", 32'd2, 32'd1);
        if (ndone > 0) check("held_period", i - last_done, 32'd6);
        else check("held_first_done", i, 32'd5);
        compare_result($sformatf("held%0d", ndone));
        ndone++;
        last_done = i;
      end
      prev_done = bus.done;
    end
    check("held_done_count", ndone, 32'd4);

    // Reset while CALC holds index 2.
    @(negedge clk);
    bus.a_in  = 16'h7777;
    bus.b_in  = 16'h1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_partial", {16'h0, bus.sum_out}, 32'h0077);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy_done", {30'h0, bus.busy, bus.done}, 32'd0);
    check("midrst_sum",  {16'h0, bus.sum_out}, 32'd0);
    check("midrst_mask", {28'h0, bus.sat_mask}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 32'd0);
    run_op("after_reset", 16'h1284, 16'h1111, 1'b0, 1'b0);
    check("scoreboard_drained", sb.size(), 32'd0);

    cycles = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
